// File: rtl/md5_pkg.sv
// Shared types, constants and helpers for the MD5 round controller.
// The message-word schedule lives here so datapath and control agree.
package md5_pkg;

  localparam int NUM_STEPS = 64;

  localparam logic [31:0] MD5_IV_A = 32'h67452301;
  localparam logic [31:0] MD5_IV_B = 32'hefcdab89;
  localparam logic [31:0] MD5_IV_C = 32'h98badcfe;
  localparam logic [31:0] MD5_IV_D = 32'h10325476;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_ROUND,
    S_ADD,
    S_DONE
  } md5_ctrl_state_t;

  // Message word index g for step i; all arithmetic is mod 16.
  function automatic logic [3:0] md5_g(input logic [5:0] step);
    logic [3:0] i;
    logic [3:0] g;
    i = step[3:0];
    case (step[5:4])
      2'd0:    g = i;
      2'd1:    g = i * 4'd5 + 4'd1;
      2'd2:    g = i * 4'd3 + 4'd5;
      default: g = i * 4'd7;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/md5_msg_sched.sv
// Combinational step index to round-function select and message word.
// Registered by the controller so the datapath sees aligned values.
module md5_msg_sched
  import md5_pkg::*;
#(
  parameter int STEP_W = 6
) (
  input  logic [STEP_W-1:0] step_i,
  output logic [1:0]        func_sel_o,
  output logic [3:0]        msg_idx_o
);

  logic [5:0] step6;

  assign step6      = 6'(step_i);
  assign func_sel_o = step6[5:4];
  assign msg_idx_o  = md5_g(step6);

endmodule

// File: rtl/md5_round_ctrl.sv
// MD5 compression sequencer: init, 64 steps, hash add, done pulse.
// Step outputs are registered from the next-state counter value.
module md5_round_ctrl
  import md5_pkg::*;
#(
  parameter int NUM_STEPS = md5_pkg::NUM_STEPS,
  parameter int STEP_W    = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              first_block,
  input  logic              dp_stall,
  output logic              busy,
  output logic              ld_iv,
  output logic              ld_abcd,
  output logic              step_en,
  output logic [STEP_W-1:0] step_idx,
  output logic [1:0]        func_sel,
  output logic [3:0]        msg_idx,
  output logic              add_hash,
  output logic              done
);

  md5_ctrl_state_t   state_q, state_d;
  logic [STEP_W-1:0] cnt_q, cnt_d;
  logic              fb_q, fb_d;
  logic [1:0]        fs_q, fs_d, fs_n;
  logic [3:0]        mi_q, mi_d, mi_n;
  logic              last_step;

  assign last_step = (cnt_q == STEP_W'(NUM_STEPS - 1));

  md5_msg_sched #(
    .STEP_W(STEP_W)
  ) u_sched (
    .step_i    (cnt_d),
    .func_sel_o(fs_n),
    .msg_idx_o (mi_n)
  );

  // Next-state, counter and strobe decode.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    fb_d     = fb_q;
    busy     = 1'b1;
    ld_iv    = 1'b0;
    ld_abcd  = 1'b0;
    step_en  = 1'b0;
    add_hash = 1'b0;
    done     = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy  = 1'b0;
        cnt_d = '0;
        if (start) begin
          state_d = S_INIT;
          fb_d    = first_block;
        end
      end
      S_INIT: begin
        ld_abcd = 1'b1;
        ld_iv   = fb_q;
        cnt_d   = '0;
        state_d = S_ROUND;
      end
      S_ROUND: begin
        if (!dp_stall) begin
          step_en = 1'b1;
          if (last_step) begin
            cnt_d   = '0;
            state_d = S_ADD;
          end else begin
            cnt_d = cnt_q + STEP_W'(1);
          end
        end
      end
      S_ADD: begin
        add_hash = 1'b1;
        state_d  = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        busy    = 1'b0;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Step outputs are non-zero only while the next state is ROUND.
  always_comb begin
    fs_d = '0;
    mi_d = '0;
    if (state_d == S_ROUND) begin
      fs_d = fs_n;
      mi_d = mi_n;
    end
  end

  // State, counter and registered step outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      fb_q    <= 1'b0;
      fs_q    <= '0;
      mi_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fb_q    <= fb_d;
      fs_q    <= fs_d;
      mi_q    <= mi_d;
    end
  end

  assign step_idx = cnt_q;
  assign func_sel = fs_q;
  assign msg_idx  = mi_q;

endmodule
